sw_test_status_mon: RTL

- Downstream consumer of the simulation SRAM write channel in the Verilator chip testbench.
- Decodes 16-bit software test-status writes to a programmable status address.
- Tracks test progress in a state machine and runs a no-progress watchdog.
- Produces sticky done/passed/timeout verdicts for the top-level termination logic.

---
 rtl/sw_test_status_mon_pkg.sv | 21 ++
 rtl/sw_test_status_wdog.sv | 16 +
 rtl/sw_test_status_mon.sv | 80 ++++++++
 3 files changed

// File: rtl/sw_test_status_mon_pkg.sv
// sw_test_status_mon_pkg: status codes, monitor states and helpers shared by the test-status monitor
package sw_test_status_mon_pkg;
  typedef enum logic [15:0] {
    UNDER_RESET = 16'h0000,
    IN_BOOT_ROM = 16'hB090,
    IN_TEST     = 16'h4354,
    PASSED      = 16'h900D,
    FAILED      = 16'hBAAD
  } sw_status_code_e;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BOOT = 3'd1,
    TEST = 3'd2,
    PASS = 3'd3,
    FAIL = 3'd4,
    TOUT = 3'd5
  } mon_state_e;
  function automatic logic is_terminal(input mon_state_e s);
    return s == PASS || s == FAIL || s == TOUT;
  endfunction
endpackage

// File: rtl/sw_test_status_wdog.sv
// sw_test_status_wdog: no-progress watchdog; clk_i/rst_ni (sync, active-low), clear restarts, run enables counting, expire flags the last allowed cycle
module sw_test_status_wdog #(
  parameter int unsigned TimeoutCycles = 32'd10_000_000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic run,
  output logic expire
);
  logic [CntWidth-1:0] cnt;
  assign expire = TimeoutCycles != 0 && run && cnt == CntWidth'(TimeoutCycles - 1);
  always_ff @(posedge clk_i)
    cnt <= (!rst_ni || clear || !run || TimeoutCycles == 0) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sw_test_status_mon.sv
// sw_test_status_mon: decodes sw test-status writes into a progress FSM with watchdog and sticky done/passed/timeout verdicts
// Ports: clk_i, rst_ni (sync, active-low); wr_valid_i/addr_i/data_i write channel; status_addr_i status address;
// state_o, last_status_o, write_count_o (saturating), illegal_o pulse, done_o/passed_o/timeout_o sticky verdicts.
// Optional SW_TEST_STATUS_MON_TRACE_EN: transition trace lines and verdict assertions.
module sw_test_status_mon
  import sw_test_status_mon_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 32'd10_000_000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [15:0]          data_i,
  input  logic [AddrWidth-1:0] status_addr_i,
  output logic [2:0]           state_o,
  output logic [15:0]          last_status_o,
  output logic [CntWidth-1:0]  write_count_o,
  output logic                 illegal_o,
  output logic                 done_o,
  output logic                 passed_o,
  output logic                 timeout_o
);
  mon_state_e state_q;
  logic accept, run, expire;
  assign accept    = wr_valid_i && addr_i == status_addr_i && !done_o;
  assign run       = state_q == BOOT || state_q == TEST;
  assign state_o   = state_q;
  assign done_o    = is_terminal(state_q);
  assign passed_o  = state_q == PASS;
  assign timeout_o = state_q == TOUT;
  sw_test_status_wdog #(
    .TimeoutCycles(TimeoutCycles),
    .CntWidth     (CntWidth)
  ) u_wdog (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clear (accept),
    .run   (run),
    .expire(expire)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_status_o <= '0;
      write_count_o <= '0;
      illegal_o     <= 1'b0;
    end else begin
      illegal_o <= accept && state_q == IDLE && (data_i == PASSED || data_i == FAILED);
      if (accept) begin
        last_status_o <= data_i;
        write_count_o <= &write_count_o ? write_count_o : write_count_o + 1'b1;
        state_q <= state_q == IDLE ?
                     (data_i == IN_BOOT_ROM ? BOOT : data_i == IN_TEST ? TEST : IDLE) :
                     (data_i == PASSED      ? PASS :
                      data_i == FAILED      ? FAIL :
                      data_i == UNDER_RESET ? IDLE :
                      data_i == IN_TEST     ? TEST :
                      data_i == IN_BOOT_ROM ? BOOT : state_q);
      end else if (expire) begin
        state_q <= TOUT;
      end
    end
  end
`ifdef SW_TEST_STATUS_MON_TRACE_EN
  logic [63:0] cyc_q;
  mon_state_e  prev_q;
  always_ff @(posedge clk_i) begin
    cyc_q  <= !rst_ni ? '0 : cyc_q + 1'b1;
    prev_q <= state_q;
    if (rst_ni && prev_q != state_q)
      $display("sw_test_status_mon cycle %0d: %s -> %s code %h", cyc_q, prev_q.name(), state_q.name(), last_status_o);
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |=> done_o);
  assert property (@(posedge clk_i) disable iff (!rst_ni) passed_o |-> done_o);
`else
`endif
endmodule
